multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 81 ++++++++
 rtl/mem_wait_timer.sv | 57 +++++
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mips_ctrl_pkg
//  Brief  : Shared encodings for the multicycle MIPS control unit. Holds the
//           FSM state codes, the opcode constants and the alu_op, pc_src and
//           alu_src_b select encodings. Also holds the control-output bundle
//           and a helper that identifies the states that issue a memory
//           request.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

  // FSM state encodings. These values also appear on the debug state port.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EXEC   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd12;

  // Opcode field values (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // alu_op encodings.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  // pc_src encodings.
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // alu_src_b encodings.
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Control-output bundle. ext_op is not part of it because ext_op is
  // registered separately and is not a per-state decode.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       fault;
  } ctrl_t;

  // States that drive mem_req and therefore run the wait timer.
  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module : mem_wait_timer
//  Brief  : Counts consecutive memory-wait cycles in a memory-request state
//           and flags a timeout. The count restarts whenever the controller
//           changes state. The timeout flag is raised in the wait cycle that
//           would make the count reach TIMEOUT_CYCLES, so the controller can
//           redirect to FAULT on that same edge.
//  Ports  : clk        in   clock
//           rst_n      in   async active-low reset
//           clear      in   restart the count (state is changing)
//           wait_en    in   controller is in a memory-request state
//           mem_ready  in   memory handshake
//           timeout    out  this wait cycle exhausts the budget
//  Rev    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic wait_en,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] C_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       stall;

  assign stall   = wait_en & ~mem_ready;
  // Counts 0..TIMEOUT_CYCLES-1 are the already-elapsed wait cycles. The wait
  // cycle seen with the last count is the TIMEOUT_CYCLES-th one.
  assign timeout = stall & (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : multicycle_ctrl
//  Brief  : Multicycle MIPS control FSM (lw/sw/R-type/addi/andi/ori/beq/bne/j)
//           with a memory-wait timeout that parks the FSM in a sticky FAULT
//           state until reset.
//  Macro  : MULTICYCLE_CTRL_ZERO_EXT_EN - when defined, ext_op selects zero
//           extension for andi/ori. When undefined, ext_op is tied to 1.
//  Ports  : clk, rst_n                 clock, async active-low reset
//           opcode, funct, zero        IR fields and ALU zero flag
//           mem_req/mem_we/iord        memory interface controls
//           mem_ready                  memory handshake
//           ir_we, pc_we, pc_src       IR/PC load controls
//           alu_src_a/alu_src_b/alu_op ALU operand and operation selects
//           reg_we, reg_dst, mem_to_reg register-file write controls
//           ext_op                     immediate extender mode (1 = sign)
//           state                      current FSM state (debug)
//           fault                      sticky timeout / illegal-opcode flag
//  Rev    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       mem_req,
  input  logic       mem_ready,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ext_op,
  output logic [3:0] state,
  output logic       fault
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;
  logic       timeout;
  logic       wait_en;
  logic       clear;

  // funct is decoded by the downstream ALU control, not by this FSM.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign wait_en = is_mem_state(state_q);
  assign clear   = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .wait_en   (wait_en),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // Next state and control decode. mem_ready takes priority over timeout,
  // so a handshake in the last allowed wait cycle still advances normally.
  always_comb begin
    state_d  = state_q;
    ctrl_raw = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_raw.mem_req   = 1'b1;
        ctrl_raw.alu_src_b = SRCB_FOUR;
        ctrl_raw.alu_op    = ALU_ADD;
        ctrl_raw.pc_src    = PC_ALU;
        if (mem_ready) begin
          ctrl_raw.ir_we = 1'b1;
          ctrl_raw.pc_we = 1'b1;
          state_d        = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        // Branch target precompute: PC + (imm << 2).
        ctrl_raw.alu_src_b = SRCB_IMM_SH2;
        ctrl_raw.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                 state_d = S_R_EXEC;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          OP_J:                     state_d = S_JUMP;
          default:                  state_d = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = ALU_ADD;
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl_raw.mem_req = 1'b1;
        ctrl_raw.iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_MEM_WB: begin
        ctrl_raw.reg_we     = 1'b1;
        ctrl_raw.mem_to_reg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_raw.mem_req = 1'b1;
        ctrl_raw.mem_we  = 1'b1;
        ctrl_raw.iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_R_EXEC: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_RT;
        ctrl_raw.alu_op    = ALU_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        ctrl_raw.reg_we  = 1'b1;
        ctrl_raw.reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ?
                             ALU_LOGIC : ALU_ADD;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        ctrl_raw.reg_we = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_RT;
        ctrl_raw.alu_op    = ALU_SUB;
        ctrl_raw.pc_src    = PC_ALUOUT;
        ctrl_raw.pc_we     = (opcode == OP_BNE) ? ~zero : zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctrl_raw.pc_src = PC_JUMP;
        ctrl_raw.pc_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        ctrl_raw.fault = 1'b1;
      end
      default: begin
        // Unused encodings can only be reached through an upset.
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset resets state_q to FETCH, whose decode drives mem_req. Gating with
  // rst_n keeps every strobe low while reset is held; mem_req then rises as
  // soon as reset is released.
  assign ctrl = rst_n ? ctrl_raw : '0;

`ifdef MULTICYCLE_CTRL_ZERO_EXT_EN
  logic ext_op_q;
  logic ext_op_d;

  // Captured when DECODE is left, so the choice stays stable through the
  // execute and write-back states that use the extended immediate.
  always_comb begin
    ext_op_d = ext_op_q;
    if (state_q == S_DECODE) begin
      ext_op_d = !((opcode == OP_ANDI) || (opcode == OP_ORI));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_op_q <= 1'b1;
    end else begin
      ext_op_q <= ext_op_d;
    end
  end

  assign ext_op = ext_op_q;
`else
  assign ext_op = 1'b1;
`endif

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_we     = ctrl.reg_we;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign fault      = ctrl.fault;
  assign state      = state_q;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_multicycle_ctrl
//  Brief  : Self-checking bench for multicycle_ctrl. Each driven cycle pushes
//           the expected output vector into a scoreboard. A monitor pops it
//           on the falling edge and compares it with the DUT outputs.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int C_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_req;
  logic       mem_ready;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ext_op;
  logic [3:0] state;
  logic       fault;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(C_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ext_op     (ext_op),
    .state      (state),
    .fault      (fault)
  );

  // {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
  //  alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, ext_op, fault}
  logic [20:0] obs;
  assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, ext_op, fault};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];
  string       cur_tag;
  logic        cur_ext;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected outputs for one cycle, written from the state behaviour table.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic mr,
                                          input logic z, input logic [5:0] op,
                                          input logic ext);
    logic       mreq, mwe, io, irw, pcw, a, rw, rd, m2r, flt;
    logic [1:0] pcs, b, aop;
    {mreq, mwe, io, irw, pcw, a, rw, rd, m2r, flt} = '0;
    pcs = 2'b00; b = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:    begin mreq = 1; b = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:   b = 2'b11;
      S_MEM_ADDR: begin a = 1; b = 2'b10; end
      S_MEM_RD:   begin mreq = 1; io = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mreq = 1; mwe = 1; io = 1; end
      S_R_EXEC:   begin a = 1; aop = 2'b10; end
      S_R_WB:     begin rw = 1; rd = 1; end
      S_I_EXEC:   begin a = 1; b = 2'b10;
                        aop = (op == 6'b001100 || op == 6'b001101) ? 2'b11 : 2'b00; end
      S_I_WB:     rw = 1;
      S_BRANCH:   begin a = 1; aop = 2'b01; pcs = 2'b01;
                        pcw = (op == 6'b000100) ? z : ~z; end
      S_JUMP:     begin pcs = 2'b10; pcw = 1; end
      S_FAULT:    flt = 1;
      default:    flt = 0;
    endcase
    return {st, mreq, mwe, io, irw, pcw, pcs, a, b, aop, rw, rd, m2r, ext, flt};
  endfunction

  // One driven cycle: drive inputs, record the expectation, advance.
  task automatic step(input logic [3:0] st, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(exp_vec(st, mr, z, opcode, cur_ext));
    tag_q.push_back($sformatf("%s_st%0d", cur_tag, st));
    if (st == S_DECODE) begin
`ifdef MULTICYCLE_CTRL_ZERO_EXT_EN
      cur_ext = !(opcode == 6'b001100 || opcode == 6'b001101);
`else
      cur_ext = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle with reset asserted: state FETCH, all strobes low, ext_op 1.
  task automatic step_rst();
    exp_q.push_back({S_FETCH, 15'b0, 1'b1, 1'b0});
    tag_q.push_back({cur_tag, "_rst"});
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
    cur_tag = tag;
    opcode  = op;
    funct   = fn;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), {11'b0, obs}, {11'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    cur_ext = 1'b1; cur_tag = "reset";
    @(posedge clk);
    #1;
    step_rst();
    step_rst();
    rst_n = 1'b1;

    // lw $2, 4($1) : 0x8C220004
    instr("lw", 6'h23, 6'h04);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEM_ADDR, 1, 0);
    step(S_MEM_RD, 1, 0); step(S_MEM_WB, 1, 0);

    instr("add", OP_RTYPE, 6'h20);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_R_EXEC, 1, 0); step(S_R_WB, 1, 0);

    instr("sw", OP_SW, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEM_ADDR, 1, 0); step(S_MEM_WR, 1, 0);

    instr("addi", OP_ADDI, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_I_EXEC, 1, 0); step(S_I_WB, 1, 0);

    instr("ori", OP_ORI, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_I_EXEC, 1, 0); step(S_I_WB, 1, 0);

    instr("andi", OP_ANDI, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_I_EXEC, 1, 0); step(S_I_WB, 1, 0);

    // Branches: pc_we follows zero for beq and its inverse for bne.
    for (int i = 0; i < 4; i++) begin
      instr((i < 2) ? "beq" : "bne", (i < 2) ? OP_BEQ : OP_BNE, 6'h00);
      step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_BRANCH, 1, (i % 2 == 0));
    end

    instr("j", OP_J, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_JUMP, 1, 0);

    // lw with wait states in both FETCH and MEM_RD.
    instr("lw_wait", OP_LW, 6'h00);
    step(S_FETCH, 0, 0); step(S_FETCH, 1, 0); step(S_DECODE, 1, 0);
    step(S_MEM_ADDR, 1, 0); step(S_MEM_RD, 0, 0); step(S_MEM_RD, 0, 0);
    step(S_MEM_RD, 1, 0); step(S_MEM_WB, 1, 0);

    // Handshake on the last allowed wait cycle advances instead of faulting.
    instr("to_edge", OP_J, 6'h00);
    for (int i = 0; i < C_TIMEOUT - 1; i++) step(S_FETCH, 0, 0);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_JUMP, 1, 0);

    // Asynchronous reset while waiting in MEM_RD.
    instr("arst", OP_LW, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_MEM_ADDR, 1, 0);
    step(S_MEM_RD, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", {28'b0, state}, {28'b0, S_FETCH});
    check("arst_mem_req", {31'b0, mem_req}, 32'd0);
    cur_ext = 1'b1;
    step_rst();
    rst_n = 1'b1;
    instr("post_rst", OP_J, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0); step(S_JUMP, 1, 0);

    // Illegal opcode goes straight to FAULT and stays there.
    instr("illegal", 6'h3F, 6'h00);
    step(S_FETCH, 1, 0); step(S_DECODE, 1, 0);
    step(S_FAULT, 1, 0); step(S_FAULT, 0, 1); step(S_FAULT, 1, 1);
    rst_n = 1'b0; cur_ext = 1'b1; cur_tag = "rst2";
    step_rst();
    rst_n = 1'b1;

    // FETCH timeout: TIMEOUT wait cycles, then sticky FAULT.
    instr("timeout", OP_J, 6'h00);
    for (int i = 0; i < C_TIMEOUT; i++) step(S_FETCH, 0, 0);
    step(S_FAULT, 0, 0); step(S_FAULT, 1, 0); step(S_FAULT, 1, 1);
    rst_n = 1'b0; cur_tag = "rst3";
    step_rst();
    rst_n = 1'b1;

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl
`default_nettype wire
